// File: rtl/debug_ocimem_arbiter.sv
// Shares the debug OCI RAM between JTAG command pulses and the CPU debug Avalon slave.
// Holds one JTAG command and gives a waiting CPU priority once it has waited MAX_WAIT cycles.
module debug_ocimem_arbiter #(
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic [37:0]   jdo,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          jtag_overflow,
  input  logic          debug_lock,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic [3:0]    ram_byteen,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_JRD, S_CRD} state_t;

  state_t          state_q, state_d;
  logic            slot_vld_q, slot_vld_d;
  logic            slot_wr_q, slot_wr_d;
  logic [31:0]     slot_data_q, slot_data_d;
  logic [AW-1:0]   jaddr_q, jaddr_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]     mon_q, mon_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ovf_q, ovf_d;

  logic cpu_req, cpu_ok, cpu_prio, grant_j, grant_c, any_pulse, blocked;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[34:32]};

  always_comb begin
    state_d     = state_q;
    slot_vld_d  = slot_vld_q;
    slot_wr_d   = slot_wr_q;
    slot_data_d = slot_data_q;
    jaddr_d     = jaddr_q;
    wait_cnt_d  = wait_cnt_q;
    mon_d       = mon_q;
    rdata_d     = rdata_q;
    ovf_d       = ovf_q;

    ram_addr        = jaddr_q;
    ram_wren        = 1'b0;
    ram_byteen      = 4'hF;
    ram_wdata       = slot_data_q;
    avs_waitrequest = 1'b1;

    cpu_req  = avs_read | avs_write;
    cpu_ok   = cpu_req & ~debug_lock;
    cpu_prio = cpu_ok && (wait_cnt_q >= WCW'(MAX_WAIT));
    grant_j  = (state_q == S_IDLE) && slot_vld_q && !cpu_prio;
    grant_c  = (state_q == S_IDLE) && cpu_ok && !grant_j;

    if (grant_j) begin
      ram_wren   = slot_wr_q;
      jaddr_d    = jaddr_q + AW'(1);
      slot_vld_d = 1'b0;
      if (!slot_wr_q) state_d = S_JRD;
    end

    if (grant_c) begin
      ram_addr   = avs_address;
      ram_wren   = avs_write;
      ram_byteen = avs_byteenable;
      ram_wdata  = avs_writedata;
      wait_cnt_d = '0;
      if (avs_read) state_d = S_CRD;
      else          avs_waitrequest = 1'b0;
    end else if (cpu_req && state_q != S_CRD && wait_cnt_q < WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    case (state_q)
      S_JRD: begin
        mon_d   = ram_rdata;
        state_d = S_IDLE;
      end
      S_CRD: begin
        rdata_d         = ram_rdata;
        avs_waitrequest = 1'b0;
        state_d         = S_IDLE;
      end
      default: ;
    endcase

    // A full slot (even one being granted now) or a read in flight rejects the pulse.
    any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    blocked   = slot_vld_q || (state_q == S_JRD);
    if (any_pulse && blocked) begin
      ovf_d = 1'b1;
    end else if (take_action_ocimem_a) begin
      jaddr_d = jdo[AW+1:2];
      if (jdo[35]) begin
        slot_vld_d = 1'b1;
        slot_wr_d  = 1'b0;
      end
    end else if (take_action_ocimem_b) begin
      slot_vld_d  = 1'b1;
      slot_wr_d   = 1'b1;
      slot_data_d = jdo[31:0];
    end else if (take_no_action_ocimem_a) begin
      slot_vld_d = 1'b1;
      slot_wr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      slot_vld_q  <= 1'b0;
      slot_wr_q   <= 1'b0;
      slot_data_q <= '0;
      jaddr_q     <= '0;
      wait_cnt_q  <= '0;
      mon_q       <= '0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_vld_q  <= slot_vld_d;
      slot_wr_q   <= slot_wr_d;
      slot_data_q <= slot_data_d;
      jaddr_q     <= jaddr_d;
      wait_cnt_q  <= wait_cnt_d;
      mon_q       <= mon_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
    end
  end

  // CPU read data is passed straight through in the response cycle, then held.
  assign avs_readdata  = (state_q == S_CRD) ? ram_rdata : rdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = !slot_vld_q && (state_q != S_JRD);
  assign jtag_overflow = ovf_q;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed bench for debug_ocimem_arbiter with a one-cycle-latency RAM model.
module tb_debug_ocimem_arbiter;
  localparam int AW = 8;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic take_a = 0, take_b = 0, take_n = 0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic monitor_ready, jtag_overflow;
  logic debug_lock = 0;
  logic [AW-1:0] avs_address = '0;
  logic avs_read = 0, avs_write = 0;
  logic [31:0] avs_writedata = '0;
  logic [3:0] avs_byteenable = 4'hF;
  logic [31:0] avs_readdata;
  logic avs_waitrequest;
  logic [AW-1:0] ram_addr;
  logic ram_wren;
  logic [3:0] ram_byteen;
  logic [31:0] ram_wdata, ram_rdata;

  int checks = 0, errors = 0;
  logic [31:0] mem [0:255];

  debug_ocimem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_n), .jdo(jdo),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overflow(jtag_overflow),
    .debug_lock(debug_lock), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic neg;  @(negedge clk); endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jaddr_cmd(input logic [7:0] a, input logic rd);
    logic [37:0] d;
    d = '0;
    d[AW+1:2] = a;
    d[35] = rd;
    return d;
  endfunction

  // Drives a one-cycle pulse; returns at the start of the following cycle.
  task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] d);
    take_a = a; take_b = b; take_n = n; jdo = d;
    tick;
    take_a = 0; take_b = 0; take_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int npulse, waited, budget;
    logic granted;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h11] = 32'h1111_0011;
    mem[8'h20] = 32'h2020_2020;
    mem[8'hFF] = 32'hFFFF_00FF;
    mem[8'h00] = 32'h0000_A5A5;

    // Reset state
    tick; tick; neg;
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_ready", monitor_ready, 1);
    chk("rst_ovf", jtag_overflow, 0);
    chk("rst_wait", avs_waitrequest, 1);
    chk("rst_wren", ram_wren, 0);
    chk("rst_rdata", avs_readdata, 0);
    tick; reset_n = 1;

    // Address load, then write DEADBEEF at 0x10
    pulse(1, 0, 0, jaddr_cmd(8'h10, 0));
    neg; chk("load_ready", monitor_ready, 1);
    tick; pulse(0, 1, 0, 38'h00DEADBEEF);
    neg;
    chk("wr_wren", ram_wren, 1);
    chk("wr_addr", ram_addr, 32'h10);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
    chk("wr_ready_low", monitor_ready, 0);
    tick; neg;
    chk("wr_mem", mem[8'h10], 32'hDEADBEEF);
    chk("wr_ready_high", monitor_ready, 1);
    chk("wr_wren_off", ram_wren, 0);

    // Read via no_action shows jaddr advanced to 0x11
    tick; pulse(0, 0, 1, '0);
    neg; chk("inc_addr", ram_addr, 32'h11);
    tick; tick; neg;
    chk("inc_mondreg", MonDReg, 32'h1111_0011);

    // Load 0x10 with read
    tick; pulse(1, 0, 0, jaddr_cmd(8'h10, 1));
    neg; chk("jrd_addr", ram_addr, 32'h10); chk("jrd_ready_g", monitor_ready, 0);
    tick; neg; chk("jrd_ready_g1", monitor_ready, 0); chk("jrd_mon_g1", MonDReg, 32'h1111_0011);
    tick; neg; chk("jrd_mon_g2", MonDReg, 32'hDEADBEEF); chk("jrd_ready_g2", monitor_ready, 1);

    // CPU read of 0x10
    tick; avs_read = 1; avs_address = 8'h10;
    neg; chk("crd_wait_g", avs_waitrequest, 1); chk("crd_addr", ram_addr, 32'h10);
    tick; neg; chk("crd_wait_g1", avs_waitrequest, 0); chk("crd_data", avs_readdata, 32'hDEADBEEF);
    tick; avs_read = 0;
    neg; chk("crd_wait_after", avs_waitrequest, 1); chk("crd_hold", avs_readdata, 32'hDEADBEEF);

    // Two pulses during/after a CPU read: first buffered, second dropped
    tick; avs_read = 1; avs_address = 8'h20;
    neg; chk("ovf_cpu_wait", avs_waitrequest, 1);
    tick; take_n = 1;
    neg; chk("ovf_cpu_done", avs_waitrequest, 0); chk("ovf_cpu_data", avs_readdata, 32'h2020_2020);
    tick; avs_read = 0;
    neg; chk("ovf_j_addr", ram_addr, 32'h11); chk("ovf_j_wren", ram_wren, 0); chk("ovf_pre", jtag_overflow, 0);
    tick; take_n = 0;
    neg; chk("ovf_set", jtag_overflow, 1); chk("ovf_ready", monitor_ready, 0);
    tick; neg; chk("ovf_mon", MonDReg, 32'h1111_0011); chk("ovf_ready2", monitor_ready, 1);

    // Address wrap at the top of the RAM
    tick; pulse(1, 0, 0, jaddr_cmd(8'hFF, 0));
    pulse(0, 0, 1, '0);
    neg; chk("wrap_top_addr", ram_addr, 32'hFF);
    tick; tick; neg; chk("wrap_top_mon", MonDReg, 32'hFFFF_00FF);
    tick; pulse(0, 0, 1, '0);
    neg; chk("wrap_zero_addr", ram_addr, 32'h00);
    tick; tick; neg; chk("wrap_zero_mon", MonDReg, 32'h0000_A5A5);

    // debug_lock holds the CPU off while JTAG proceeds; released CPU then beats a pending command
    tick; debug_lock = 1; avs_read = 1; avs_address = 8'h10;
    take_a = 1; jdo = jaddr_cmd(8'h30, 0);
    neg; chk("lock_wait0", avs_waitrequest, 1);
    tick; take_a = 0; take_b = 1; jdo = 38'h00CAFEF00D;
    neg; chk("lock_wait1", avs_waitrequest, 1);
    tick; take_b = 0;
    neg; chk("lock_jwr_wren", ram_wren, 1); chk("lock_jwr_addr", ram_addr, 32'h30);
    chk("lock_wait2", avs_waitrequest, 1);
    for (int i = 0; i < 3; i++) begin
      tick; neg; chk("lock_wait_hold", avs_waitrequest, 1);
    end
    tick; take_b = 1; jdo = 38'h00BEEF0001;
    neg; chk("lock_wait_l", avs_waitrequest, 1);
    tick; take_b = 0; debug_lock = 0;
    neg; chk("prio_cpu_addr", ram_addr, 32'h10); chk("prio_cpu_wren", ram_wren, 0);
    chk("prio_cpu_wait", avs_waitrequest, 1);
    tick; neg; chk("prio_cpu_done", avs_waitrequest, 0); chk("prio_cpu_data", avs_readdata, 32'hDEADBEEF);
    tick; avs_read = 0;
    neg; chk("prio_j_wren", ram_wren, 1); chk("prio_j_addr", ram_addr, 32'h31);
    chk("prio_j_wdata", ram_wdata, 32'hBEEF0001);
    tick; neg;
    chk("lock_mem30", mem[8'h30], 32'hCAFEF00D);
    chk("lock_mem31", mem[8'h31], 32'hBEEF0001);
    chk("ovf_sticky", jtag_overflow, 1);

    // Reset during a JTAG read aborts it
    tick; pulse(1, 0, 0, jaddr_cmd(8'h30, 1));
    tick; reset_n = 0;
    tick; reset_n = 1;
    neg;
    chk("abort_mon", MonDReg, 0);
    chk("abort_ready", monitor_ready, 1);
    chk("abort_ovf", jtag_overflow, 0);
    chk("abort_rdata", avs_readdata, 0);

    // CPU write held while JTAG streams reads back-to-back
    tick;
    npulse = 0; waited = 0; granted = 0;
    for (int i = 0; i < 16; i++) begin
      take_n = monitor_ready;
      if (monitor_ready) npulse++;
      if (i == 2) begin
        avs_write = 1; avs_address = 8'h40; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
      end
      neg;
      if (avs_write) begin
        if (avs_waitrequest) waited++;
        else granted = 1;
      end
      tick; take_n = 0;
      if (granted) avs_write = 0;
    end
    chk("stream_granted", granted, 1);
    chk("stream_bound", (waited <= MAX_WAIT + 3), 1);
    chk("stream_npulse", npulse, 6);
    budget = 0;
    while (!monitor_ready && budget < 10) begin tick; budget++; end
    chk("stream_drain", monitor_ready, 1);
    pulse(0, 0, 1, '0);
    neg;
    chk("stream_jaddr", ram_addr, npulse);
    chk("stream_ovf", jtag_overflow, 0);
    chk("stream_mem40", mem[8'h40], 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_ocimem_arbiter.md
# debug_ocimem_arbiter

Sequences and shares the debug on-chip memory (OCI RAM, 2^AW x 32, one-cycle read latency) between two masters. The first is the JTAG debug slave's system-clock command pulses (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo). The second is the CPU's debug Avalon-MM slave port. It sits between the debug slave wrapper and the OCI RAM instance in the nios2_gen2 CPU debug module. It grants one RAM access per cycle, buffers one JTAG command and prevents CPU starvation.

## Interface
Parameters:
- AW, 8, OCI RAM word-address width
- MAX_WAIT, 4, CPU wait cycles after which the CPU beats a pending JTAG command

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- take_action_ocimem_a  in  1  one-cycle pulse: load address, optional read
- take_action_ocimem_b  in  1  one-cycle pulse: write jdo[31:0] at address, then increment
- take_no_action_ocimem_a  in  1  one-cycle pulse: read at address, then increment
- jdo  in  38  JTAG data
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  high when no JTAG command is pending or in flight
- jtag_overflow  out  1  sticky; a JTAG pulse arrived while the slot was full
- debug_lock  in  1  high: CPU accesses are never granted
- avs_address  in  AW  CPU word address
- avs_read / avs_write  in  1  CPU strobes; mutually exclusive
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte enables
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  Avalon waitrequest
- ram_addr  out  AW  RAM address
- ram_wren  out  1  RAM write enable
- ram_byteen  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; valid the cycle after a read address is issued

## Operation
- JTAG address register jaddr[AW-1:0].
  - On take_action_ocimem_a: jaddr <= jdo[AW+1:2]. If jdo[35]=1, a read is queued at the new address.
  - On take_action_ocimem_b: a write of jdo[31:0] is queued, all byte enables set.
  - On take_no_action_ocimem_a: a read is queued.
- jaddr increments modulo 2^AW when a queued write or read is granted. There is no increment on address-load-only; wrap from 2^AW-1 goes to 0.
- Pending slot (1 entry: op, data).
  - A pulse that arrives while the slot is full, or while a JTAG read is in flight, is dropped: jaddr is unchanged and jtag_overflow is set.
  - jtag_overflow clears only on reset.
- States:
  - IDLE: grants at most one request per cycle.
  - JRD: JTAG read in flight.
  - CRD: CPU read in flight.
- IDLE arbitration:
  - A pending JTAG request wins.
  - Exception: the CPU wins if a CPU request is present, debug_lock=0, and wait_cnt >= MAX_WAIT.
  - wait_cnt counts cycles in which a CPU request is present but not granted. It saturates at MAX_WAIT and clears on CPU grant.
- Granted writes complete in the grant cycle; the FSM stays in IDLE. Granted reads go to JRD or CRD.
- JRD: MonDReg <= ram_rdata, then return to IDLE.
- CRD: avs_readdata = ram_rdata, then return to IDLE. No new grant is issued in JRD or CRD.
- ram_wren=0 whenever no write is granted. ram_addr/ram_wdata are don't-care when idle.

## Timing
- Reset values: MonDReg=0, monitor_ready=1, jtag_overflow=0, avs_readdata=0, avs_waitrequest=1, ram_wren=0, jaddr=0, wait_cnt=0, state IDLE, slot empty.
- A JTAG pulse in cycle N makes the slot valid in N+1. The earliest grant is N+1, and ram_* are driven combinationally in the grant cycle.
- JTAG read: MonDReg is updated at the end of grant+1. monitor_ready rises in grant+2.
- CPU write: avs_waitrequest=0 in the grant cycle.
- CPU read: the address is issued in the grant cycle G. avs_waitrequest=0 and readdata are valid in G+1. Minimum read latency is 2 cycles.
- avs_waitrequest=1 in every other cycle, including whenever debug_lock=1.
- A JTAG pulse arriving while the slot is empty and the same-cycle grant is going to the CPU is accepted, not dropped.
- Reset asserted mid-read aborts the access; MonDReg and avs_readdata keep their reset values.

## Test plan
- Reset, then ocimem_a with jdo[AW+1:2]=0x10 and jdo[35]=0, then ocimem_b with jdo[31:0]=0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, jaddr=0x11.
- ocimem_a with address 0x10 and jdo[35]=1 -> MonDReg=0xDEADBEEF two cycles after the grant; monitor_ready goes low then high.
- CPU read of 0x10 with no JTAG traffic -> avs_waitrequest high 1 cycle, avs_readdata=0xDEADBEEF with waitrequest=0 in the second cycle.
- CPU write held continuously while JTAG streams reads back-to-back -> CPU granted within MAX_WAIT+3 cycles; no JTAG command lost.
- jaddr=2^AW-1, take_no_action_ocimem_a -> read at the top address, jaddr wraps to 0.
- Two JTAG pulses in consecutive cycles while a CPU read is in CRD -> first is buffered and executed, second is dropped with jtag_overflow=1. Also: debug_lock=1 with a CPU read -> waitrequest stays 1 indefinitely, and JTAG accesses proceed.
